// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between an upstream stage, the inter-stage register and
// the downstream stage. The register itself takes the slave view; whatever
// drives the upstream bus and the downstream accept takes the master view.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);

  // upstream side
  logic              up_valid;
  logic              up_ready_go;
  logic [DATA_W-1:0] up_data;
  logic              allow_in;

  // downstream side
  logic              dn_valid;
  logic [DATA_W-1:0] dn_data;
  logic              dn_accept;

  // control and observation
  logic              flush;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output up_valid,
    output up_ready_go,
    output up_data,
    output dn_accept,
    output flush,
    input  allow_in,
    input  dn_valid,
    input  dn_data,
    input  occ,
    input  stall_cnt
  );

  modport slave (
    input  up_valid,
    input  up_ready_go,
    input  up_data,
    input  dn_accept,
    input  flush,
    output allow_in,
    output dn_valid,
    output dn_data,
    output occ,
    output stall_cnt
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register.
// SKID=0: one entry, allow_in is a combinational function of the held valid
//         bit and the downstream accept (classic CPU stage register).
// SKID=1: two-entry skid buffer; allow_in comes straight from a flop so the
//         allow_in chain back through the pipeline is broken at this stage.
// Both modes: one-cycle push-to-dn_valid latency, flush drops every held
// entry, and a saturating counter records cycles the head waited downstream.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  pipe_stage_reg_if.slave bus
);

  // Number of valid entries described by a pair of valid bits.
  function automatic logic [1:0] occ_count(input logic head_v, input logic skid_v);
    return {1'b0, head_v} + {1'b0, skid_v};
  endfunction

  logic              allow_s;
  logic              dn_valid_s;
  logic [DATA_W-1:0] dn_data_s;
  logic [1:0]        occ_s;
  logic              stall_s;
  logic [CNT_W-1:0]  stall_cnt_r;

  // The head is presented but downstream did not take it this cycle.
  assign stall_s = dn_valid_s & ~bus.dn_accept;

  // Saturating stall counter; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  generate
    if (SKID == 0) begin : g_single

      logic              valid_r;
      logic [DATA_W-1:0] data_r;

      // Room exists when nothing is held or the held entry leaves this cycle.
      assign allow_s = ~valid_r | bus.dn_accept;

      // Single entry: load (or take a bubble) whenever allowed, else hold.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_r <= 1'b0;
          data_r  <= {DATA_W{1'b0}};
        end else if (bus.flush) begin
          valid_r <= 1'b0;
          data_r  <= data_r;
        end else if (allow_s) begin
          valid_r <= bus.up_valid & bus.up_ready_go;
          if (bus.up_ready_go) begin
            data_r <= bus.up_data;
          end else begin
            data_r <= data_r;
          end
        end else begin
          valid_r <= valid_r;
          data_r  <= data_r;
        end
      end

      assign dn_valid_s = valid_r;
      assign dn_data_s  = data_r;
      assign occ_s      = occ_count(valid_r, 1'b0);

    end else begin : g_skid

      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
      } state_t;

      state_t            state_r;
      state_t            state_s;
      logic [DATA_W-1:0] head_r;
      logic [DATA_W-1:0] head_s;
      logic [DATA_W-1:0] skid_r;
      logic [DATA_W-1:0] skid_s;
      logic              allow_r;
      logic              dn_valid_r;
      logic [1:0]        occ_r;
      logic              push_s;
      logic              pop_s;

      // Bubbles never push, so they never occupy storage.
      assign push_s = bus.up_valid & bus.up_ready_go & allow_r;
      assign pop_s  = dn_valid_r & bus.dn_accept;

      // Next-state and data-path selection; oldest entry always sits in head.
      always_comb begin
        state_s = state_r;
        head_s  = head_r;
        skid_s  = skid_r;
        if (bus.flush) begin
          state_s = ST_EMPTY;
        end else begin
          case (state_r)
            ST_EMPTY: begin
              if (push_s) begin
                head_s  = bus.up_data;
                state_s = ST_ONE;
              end else begin
                state_s = ST_EMPTY;
              end
            end
            ST_ONE: begin
              if (push_s && pop_s) begin
                head_s  = bus.up_data;
                state_s = ST_ONE;
              end else if (push_s) begin
                skid_s  = bus.up_data;
                state_s = ST_TWO;
              end else if (pop_s) begin
                state_s = ST_EMPTY;
              end else begin
                state_s = ST_ONE;
              end
            end
            ST_TWO: begin
              if (pop_s) begin
                head_s  = skid_r;
                state_s = ST_ONE;
              end else begin
                state_s = ST_TWO;
              end
            end
            default: begin
              state_s = ST_EMPTY;
            end
          endcase
        end
      end

      // State, storage and registered outputs all derive from the next state,
      // so dn_valid, occ and allow_in stay consistent with the held entries.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_r    <= ST_EMPTY;
          head_r     <= {DATA_W{1'b0}};
          skid_r     <= {DATA_W{1'b0}};
          allow_r    <= 1'b1;
          dn_valid_r <= 1'b0;
          occ_r      <= 2'd0;
        end else begin
          state_r    <= state_s;
          head_r     <= head_s;
          skid_r     <= skid_s;
          allow_r    <= (state_s != ST_TWO);
          dn_valid_r <= (state_s != ST_EMPTY);
          occ_r      <= occ_count(state_s != ST_EMPTY, state_s == ST_TWO);
        end
      end

      assign allow_s    = allow_r;
      assign dn_valid_s = dn_valid_r;
      assign dn_data_s  = head_r;
      assign occ_s      = occ_r;

    end
  endgenerate

  assign bus.allow_in  = allow_s;
  assign bus.dn_valid  = dn_valid_s;
  assign bus.dn_data   = dn_data_s;
  assign bus.occ       = occ_s;
  assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Three instances share one stimulus stream:
//   dut0: SKID=0, CNT_W=16   dut1: SKID=1, CNT_W=16   dut2: SKID=1, CNT_W=4
// Directed scenarios check fixed expected values; the random scenario checks
// every instance against a small FIFO-with-count reference model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        up_valid;
  logic        up_ready_go;
  logic [31:0] up_data;
  logic        dn_accept;
  logic        flush;

  int n_pass  = 0;
  int n_total = 0;

  pipe_stage_reg_if #(.DATA_W(32), .CNT_W(16)) i0 ();
  pipe_stage_reg_if #(.DATA_W(32), .CNT_W(16)) i1 ();
  pipe_stage_reg_if #(.DATA_W(32), .CNT_W(4))  i2 ();

  assign i0.up_valid = up_valid;  assign i1.up_valid = up_valid;  assign i2.up_valid = up_valid;
  assign i0.up_ready_go = up_ready_go;  assign i1.up_ready_go = up_ready_go;  assign i2.up_ready_go = up_ready_go;
  assign i0.up_data = up_data;  assign i1.up_data = up_data;  assign i2.up_data = up_data;
  assign i0.dn_accept = dn_accept;  assign i1.dn_accept = dn_accept;  assign i2.dn_accept = dn_accept;
  assign i0.flush = flush;  assign i1.flush = flush;  assign i2.flush = flush;

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(i0));
  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(i1));
  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4))  u2 (.clk(clk), .reset(reset), .bus(i2));

  logic        obs_allow [3];
  logic        obs_dv    [3];
  logic [31:0] obs_data  [3];
  logic [1:0]  obs_occ   [3];
  logic [15:0] obs_stall [3];

  always_comb begin
    obs_allow[0] = i0.allow_in;  obs_allow[1] = i1.allow_in;  obs_allow[2] = i2.allow_in;
    obs_dv[0]    = i0.dn_valid;  obs_dv[1]    = i1.dn_valid;  obs_dv[2]    = i2.dn_valid;
    obs_data[0]  = i0.dn_data;   obs_data[1]  = i1.dn_data;   obs_data[2]  = i2.dn_data;
    obs_occ[0]   = i0.occ;       obs_occ[1]   = i1.occ;       obs_occ[2]   = i2.occ;
    obs_stall[0] = i0.stall_cnt;
    obs_stall[1] = i1.stall_cnt;
    obs_stall[2] = {12'd0, i2.stall_cnt};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per instance an ordered list of held entries (capacity
  // 1 or 2) plus a saturating stall count.
  logic [31:0] m_ent   [3][2];
  int          m_sz    [3];
  int          m_stall [3];

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit allow, push, pop;
      int smax;
      smax = (k == 2) ? 15 : 65535;
      if (reset) begin
        m_sz[k] = 0;
        m_stall[k] = 0;
      end else begin
        if (m_sz[k] > 0 && !dn_accept && m_stall[k] < smax) m_stall[k]++;
        if (flush) begin
          m_sz[k] = 0;
        end else begin
          allow = (k == 0) ? (m_sz[k] == 0 || dn_accept) : (m_sz[k] < 2);
          push  = up_valid && up_ready_go && allow;
          pop   = (m_sz[k] > 0) && dn_accept;
          if (pop) begin
            m_ent[k][0] = m_ent[k][1];
            m_sz[k]--;
          end
          if (push) begin
            m_ent[k][m_sz[k]] = up_data;
            m_sz[k]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic v, input logic g, input logic [31:0] d,
                        input logic a, input logic f);
    up_valid = v; up_ready_go = g; up_data = d; dn_accept = a; flush = f;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++; if (obs_dv[k] !== 1'b0) $display("FAIL reset_dv dut%0d: got %b expected 0", k, obs_dv[k]); else n_pass++;
      n_total++; if (obs_occ[k] !== 2'd0) $display("FAIL reset_occ dut%0d: got %0d expected 0", k, obs_occ[k]); else n_pass++;
      n_total++; if (obs_stall[k] !== 16'd0) $display("FAIL reset_stall dut%0d: got %0d expected 0", k, obs_stall[k]); else n_pass++;
      n_total++; if (obs_allow[k] !== 1'b1) $display("FAIL reset_allow dut%0d: got %b expected 1", k, obs_allow[k]); else n_pass++;
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 32'h10 + i, 1'b1, 1'b0);
      #1;
      n_total++; if (obs_allow[0] !== 1'b1) $display("FAIL stream_allow i=%0d: got %b expected 1", i, obs_allow[0]); else n_pass++;
      tick();
      n_total++; if (obs_dv[0] !== 1'b1) $display("FAIL stream_dv i=%0d: got %b expected 1", i, obs_dv[0]); else n_pass++;
      n_total++; if (obs_data[0] !== 32'h10 + i) $display("FAIL stream_data i=%0d: got %0h expected %0h", i, obs_data[0], 32'h10 + i); else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1'b1, 1'b1, 32'hA5, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 32'hB6, 1'b0, 1'b0);
      #1;
      n_total++; if (obs_allow[0] !== 1'b0) $display("FAIL stall_allow i=%0d: got %b expected 0", i, obs_allow[0]); else n_pass++;
      n_total++; if (obs_data[0] !== 32'hA5) $display("FAIL stall_data i=%0d: got %0h expected a5", i, obs_data[0]); else n_pass++;
      tick();
    end
    n_total++; if (obs_stall[0] !== 16'd3) $display("FAIL stall_cnt: got %0d expected 3", obs_stall[0]); else n_pass++;
    n_total++; if (obs_data[0] !== 32'hA5) $display("FAIL stall_hold: got %0h expected a5", obs_data[0]); else n_pass++;
    set_in(1'b1, 1'b0, 32'hC7, 1'b1, 1'b0);
    tick();
    n_total++; if (obs_dv[0] !== 1'b0) $display("FAIL bubble_dv: got %b expected 0", obs_dv[0]); else n_pass++;
  endtask

  task automatic test_skid();
    do_reset();
    set_in(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
    #1;
    n_total++; if (obs_allow[1] !== 1'b1) $display("FAIL skid_allow_one: got %b expected 1", obs_allow[1]); else n_pass++;
    tick();
    n_total++; if (obs_occ[1] !== 2'd2) $display("FAIL skid_occ_two: got %0d expected 2", obs_occ[1]); else n_pass++;
    n_total++; if (obs_allow[1] !== 1'b0) $display("FAIL skid_allow_two: got %b expected 0", obs_allow[1]); else n_pass++;
    n_total++; if (obs_data[1] !== 32'h1) $display("FAIL skid_head_first: got %0h expected 1", obs_data[1]); else n_pass++;
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    n_total++; if (obs_occ[1] !== 2'd1) $display("FAIL skid_occ_after_pop: got %0d expected 1", obs_occ[1]); else n_pass++;
    n_total++; if (obs_data[1] !== 32'h2) $display("FAIL skid_head_second: got %0h expected 2", obs_data[1]); else n_pass++;
    n_total++; if (obs_allow[1] !== 1'b1) $display("FAIL skid_allow_after_pop: got %b expected 1", obs_allow[1]); else n_pass++;
    tick();
    n_total++; if (obs_occ[1] !== 2'd0) $display("FAIL skid_occ_empty: got %0d expected 0", obs_occ[1]); else n_pass++;
    n_total++; if (obs_dv[1] !== 1'b0) $display("FAIL skid_dv_empty: got %b expected 0", obs_dv[1]); else n_pass++;
  endtask

  task automatic test_simul();
    do_reset();
    set_in(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 32'h7, 1'b1, 1'b0);
    tick();
    n_total++; if (obs_occ[1] !== 2'd1) $display("FAIL simul_occ: got %0d expected 1", obs_occ[1]); else n_pass++;
    n_total++; if (obs_data[1] !== 32'h7) $display("FAIL simul_data: got %0h expected 7", obs_data[1]); else n_pass++;
    n_total++; if (obs_dv[1] !== 1'b1) $display("FAIL simul_dv: got %b expected 1", obs_dv[1]); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, 1'b1, 32'h21, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
    tick();
    n_total++; if (obs_occ[0] !== 2'd1) $display("FAIL flush_pre_occ dut0: got %0d expected 1", obs_occ[0]); else n_pass++;
    n_total++; if (obs_occ[1] !== 2'd2) $display("FAIL flush_pre_occ dut1: got %0d expected 2", obs_occ[1]); else n_pass++;
    set_in(1'b1, 1'b1, 32'h23, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      n_total++; if (obs_occ[k] !== 2'd0) $display("FAIL flush_occ dut%0d: got %0d expected 0", k, obs_occ[k]); else n_pass++;
      n_total++; if (obs_dv[k] !== 1'b0) $display("FAIL flush_dv dut%0d: got %b expected 0", k, obs_dv[k]); else n_pass++;
      n_total++; if (obs_allow[k] !== 1'b1) $display("FAIL flush_allow dut%0d: got %b expected 1", k, obs_allow[k]); else n_pass++;
      n_total++; if (obs_stall[k] !== 16'd1) $display("FAIL flush_stall dut%0d: got %0d expected 1", k, obs_stall[k]); else n_pass++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_in(1'b1, 1'b1, 32'h5A, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) tick();
    n_total++; if (obs_stall[2] !== 16'd15) $display("FAIL sat_stall dut2: got %0d expected 15", obs_stall[2]); else n_pass++;
    n_total++; if (obs_stall[1] !== 16'd20) $display("FAIL wide_stall dut1: got %0d expected 20", obs_stall[1]); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++; if (obs_stall[2] !== 16'd0) $display("FAIL sat_reset_stall: got %0d expected 0", obs_stall[2]); else n_pass++;
    n_total++; if (obs_dv[2] !== 1'b0) $display("FAIL sat_reset_dv: got %b expected 0", obs_dv[2]); else n_pass++;
    n_total++; if (obs_occ[2] !== 2'd0) $display("FAIL sat_reset_occ: got %0d expected 0", obs_occ[2]); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom,
             $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        logic exp_allow;
        exp_allow = (k == 0) ? (m_sz[k] == 0 || dn_accept) : (m_sz[k] < 2);
        n_total++; if (obs_dv[k] !== (m_sz[k] > 0)) $display("FAIL rnd_dv dut%0d cyc %0d: got %b expected %b", k, c, obs_dv[k], m_sz[k] > 0); else n_pass++;
        n_total++; if (obs_occ[k] !== 2'(m_sz[k])) $display("FAIL rnd_occ dut%0d cyc %0d: got %0d expected %0d", k, c, obs_occ[k], m_sz[k]); else n_pass++;
        n_total++; if (obs_allow[k] !== exp_allow) $display("FAIL rnd_allow dut%0d cyc %0d: got %b expected %b", k, c, obs_allow[k], exp_allow); else n_pass++;
        n_total++; if (obs_stall[k] !== 16'(m_stall[k])) $display("FAIL rnd_stall dut%0d cyc %0d: got %0d expected %0d", k, c, obs_stall[k], m_stall[k]); else n_pass++;
        if (m_sz[k] > 0) begin
          n_total++; if (obs_data[k] !== m_ent[k][0]) $display("FAIL rnd_data dut%0d cyc %0d: got %0h expected %0h", k, c, obs_data[k], m_ent[k][0]); else n_pass++;
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_skid();
    test_simul();
    test_flush();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
